// File: rtl/trig_qualifier.sv
// Turns the filtered trigger level into a qualified one-cycle trigger. It applies a minimum high width,
// a holdoff window, a sticky miss flag and single-shot arming. Define TRIG_EVENT_CNT_EN to add evt_cnt.
module trig_qualifier #(
   parameter int MIN_WIDTH = 4,
   parameter int HOLDOFF   = 16,
   parameter int CNT_W     = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   input  logic en,
   input  logic single,
   input  logic arm,
   input  logic clr_miss,
   output logic trig,
   output logic armed,
   output logic busy,
   output logic miss
`ifdef TRIG_EVENT_CNT_EN
   ,
   output logic [CNT_W-1:0] evt_cnt
`endif
);

   localparam int CNT_MAX = (MIN_WIDTH > HOLDOFF) ? MIN_WIDTH : HOLDOFF;
   localparam int WCNT_W  = $clog2(CNT_MAX + 1);
   localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
   localparam logic [WCNT_W-1:0] QUAL_LAST = WCNT_W'(MIN_WIDTH - 1);
   localparam logic [WCNT_W-1:0] HOLD_LAST = WCNT_W'(HOLDOFF);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_EDGE,
      ST_QUALIFY,
      ST_HOLDOFF
   } state_t;

   state_t            state_q, state_d;
   logic              din_q, din_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic              trig_q, trig_d;
   logic              armed_q, armed_d;
   logic              busy_q, busy_d;
   logic              miss_q, miss_d;
   logic              din_rise;
`ifdef TRIG_EVENT_CNT_EN
   localparam logic [CNT_W-1:0] EVT_ONE = CNT_W'(1);
   logic [CNT_W-1:0]  evt_q, evt_d;
`endif

   always_comb begin
      din_rise = din & ~din_q;
      din_d    = din;
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      trig_d   = 1'b0;
      miss_d   = miss_q;

      // An edge landing in holdoff wins over a clear in the same cycle; en has no say here.
      if ((state_q == ST_HOLDOFF) && din_rise) begin
         miss_d = 1'b1;
      end else if (clr_miss) begin
         miss_d = 1'b0;
      end

      if (!en) begin
         state_d = ST_IDLE;
         wcnt_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!single || arm) begin
                  state_d = ST_WAIT_EDGE;
                  wcnt_d  = '0;
               end
            end
            ST_WAIT_EDGE: begin
               if (din_rise) begin
                  if (MIN_WIDTH == 1) begin
                     trig_d  = 1'b1;
                     state_d = ST_HOLDOFF;
                     wcnt_d  = '0;
                  end else begin
                     state_d = ST_QUALIFY;
                     wcnt_d  = WCNT_ONE;
                  end
               end
            end
            ST_QUALIFY: begin
               if (!din) begin
                  state_d = ST_WAIT_EDGE;
                  wcnt_d  = '0;
               end else if (wcnt_q == QUAL_LAST) begin
                  trig_d  = 1'b1;
                  state_d = ST_HOLDOFF;
                  wcnt_d  = '0;
               end else begin
                  wcnt_d = wcnt_q + WCNT_ONE;
               end
            end
            ST_HOLDOFF: begin
               // The trig cycle itself is count 0, so HOLDOFF more cycles follow it.
               if (wcnt_q == HOLD_LAST) begin
                  state_d = single ? ST_IDLE : ST_WAIT_EDGE;
                  wcnt_d  = '0;
               end else begin
                  wcnt_d = wcnt_q + WCNT_ONE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               wcnt_d  = '0;
            end
         endcase
      end

      armed_d = (state_d != ST_IDLE);
      busy_d  = (state_d == ST_QUALIFY) || (state_d == ST_HOLDOFF);
`ifdef TRIG_EVENT_CNT_EN
      evt_d   = trig_d ? (evt_q + EVT_ONE) : evt_q;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         din_q   <= 1'b0;
         wcnt_q  <= '0;
         trig_q  <= 1'b0;
         armed_q <= 1'b0;
         busy_q  <= 1'b0;
         miss_q  <= 1'b0;
`ifdef TRIG_EVENT_CNT_EN
         evt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         din_q   <= din_d;
         wcnt_q  <= wcnt_d;
         trig_q  <= trig_d;
         armed_q <= armed_d;
         busy_q  <= busy_d;
         miss_q  <= miss_d;
`ifdef TRIG_EVENT_CNT_EN
         evt_q   <= evt_d;
`endif
      end
   end

   assign trig  = trig_q;
   assign armed = armed_q;
   assign busy  = busy_q;
   assign miss  = miss_q;
`ifdef TRIG_EVENT_CNT_EN
   assign evt_cnt = evt_q;
`endif

endmodule
